rom_fetch_unit: RTL and testbench

//   Instruction/data fetch sequencer sitting directly upstream of the program ROM.

---
 rtl/rom_fetch_unit.sv | 136 +++++++++++++
 tb/tb_rom_fetch_unit.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_fetch_unit.sv
// Fetch sequencer in front of the program ROM: PC-driven instruction fetch with valid/ready
// output and single-word data loads between instructions. ROM_FETCH_HALT_EN adds the halt trap.
module rom_fetch_unit #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [15:0] RESET_PC    = 16'h0000
`ifdef ROM_FETCH_HALT_EN
    ,
    parameter logic [15:0] HALT_OPCODE = 16'h0F00
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    input  logic        ld_req,
    input  logic [15:0] ld_addr,
    output logic [15:0] ld_data,
    output logic        ld_done
`ifdef ROM_FETCH_HALT_EN
    ,
    output logic        halted
`endif
);

    localparam int unsigned CntW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] WaitMax = CntW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        StFetch,
        StValid,
        StLoad
`ifdef ROM_FETCH_HALT_EN
        ,
        StHalt
`endif
    } state_e;

    state_e          state;
    logic [15:0]     pc;
    logic [CntW-1:0] wcnt;
    logic [15:0]     ld_addr_q;

    // The ROM sees the load address only while a load is in flight.
    assign rom_addr = (state == StLoad) ? ld_addr_q : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            wcnt        <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            ld_addr_q   <= '0;
            ld_data     <= '0;
            ld_done     <= 1'b0;
`ifdef ROM_FETCH_HALT_EN
            halted      <= 1'b0;
`endif
        end else begin
            ld_done <= 1'b0;
            case (state)
                StFetch: begin
                    if (jump_en) begin
                        pc   <= jump_addr;
                        wcnt <= '0;
                    end else if (wcnt == WaitMax) begin
                        instr       <= rom_data;
                        pc          <= pc + 16'd1;
                        instr_valid <= 1'b1;
                        wcnt        <= '0;
                        state       <= StValid;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                StValid: begin
                    if (jump_en) begin
                        // Held word is dropped; a same-cycle ready counts as consumed.
                        pc          <= jump_addr;
                        wcnt        <= '0;
                        instr_valid <= 1'b0;
                        state       <= StFetch;
                    end else if (instr_ready) begin
                        instr_valid <= 1'b0;
                        wcnt        <= '0;
`ifdef ROM_FETCH_HALT_EN
                        if (instr == HALT_OPCODE) begin
                            halted <= 1'b1;
                            state  <= StHalt;
                        end else
`endif
                        if (ld_req) begin
                            ld_addr_q <= ld_addr;
                            state     <= StLoad;
                        end else begin
                            state <= StFetch;
                        end
                    end
                end
                StLoad: begin
                    // A redirect only retargets the next fetch; the load runs to completion.
                    if (jump_en) begin
                        pc <= jump_addr;
                    end
                    if (wcnt == WaitMax) begin
                        ld_data <= rom_data;
                        ld_done <= 1'b1;
                        wcnt    <= '0;
                        state   <= StFetch;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
`ifdef ROM_FETCH_HALT_EN
                StHalt: begin
                    if (jump_en) begin
                        pc     <= jump_addr;
                        wcnt   <= '0;
                        halted <= 1'b0;
                        state  <= StFetch;
                    end
                end
`endif
                default: begin
                    state <= StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Scoreboard bench for rom_fetch_unit: directed scenarios, then randomized jump/stall/load
// segments checked against a ROM-plus-PC reference model.
module tb_rom_fetch_unit;

    localparam int unsigned WAIT_CYCLES = 2;
    localparam logic [15:0] HALT_OPCODE = 16'h0F00;

    logic        clk;
    logic        rst_n;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        jump_en;
    logic [15:0] jump_addr;
    logic        ld_req;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_done;
`ifdef ROM_FETCH_HALT_EN
    logic        halted;
`endif
    logic        scramble;

    int n_tests;
    int n_fail;
    logic [15:0] instr_q[$];
    logic [15:0] ld_q[$];

    rom_fetch_unit #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .RESET_PC   (16'h0000)
`ifdef ROM_FETCH_HALT_EN
        ,
        .HALT_OPCODE(HALT_OPCODE)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump_en    (jump_en),
        .jump_addr  (jump_addr),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_done    (ld_done)
`ifdef ROM_FETCH_HALT_EN
        ,
        .halted     (halted)
`endif
    );

    // Program ROM; unlisted words are zero, or an address hash once scrambling is on.
    function automatic logic [15:0] rom_word(input logic [15:0] a, input logic scr);
        logic [15:0] w;
        case (a)
            16'h0000: w = 16'h0000;
            16'h0001: w = 16'h2501;
            16'h0002: w = 16'h2500;
            16'h0003: w = 16'h6D00;
            16'h0004: w = 16'h6D05;
            16'h0005: w = 16'h4600;
            16'h0006: w = 16'h2430;
            16'h0007: w = 16'h0F00;
            16'h0100: w = 16'h00DE;
            16'h0101: w = 16'h00AD;
            16'h0102: w = 16'h00BE;
            16'h0103: w = 16'h00EF;
            default:  w = scr ? {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC3} : 16'h0000;
        endcase
        return w;
    endfunction

    assign rom_data = rom_word(rom_addr, scramble);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!instr_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!instr_valid) fail_now("valid_timeout");
    endtask

    task automatic accept_next(input logic [15:0] exp);
        int c;
        instr_q.push_back(exp);
        wait_valid(c);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    // Monitor: inputs change only on negedges, so the values seen at negedge+2 are the ones
    // the DUT acts on at the next posedge.
    initial begin : monitor
        logic        hold;
        logic [15:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("hold_valid", instr_valid, 1);
                    check("hold_instr", instr, held);
                end
                if (instr_valid && instr_ready) begin
                    if (instr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL instr_unexpected: got %0h, none expected", instr);
                    end else begin
                        check("instr", instr, instr_q.pop_front());
                    end
                end
                if (ld_done) begin
                    if (ld_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ld_unexpected: got %0h, none expected", ld_data);
                    end else begin
                        check("ld_data", ld_data, ld_q.pop_front());
                    end
                end
                hold = instr_valid && !instr_ready && !jump_en;
                held = instr;
            end
        end
    end

    initial begin : stimulus
        int          c;
        int          n;
        int          budget;
        bit          abort;
        bit          exp_halt;
        logic [15:0] a;
        logic [15:0] w;
        logic [15:0] halt_pc;

        n_tests = 0;
        n_fail = 0;
        abort = 1'b0;
        halt_pc = '0;
        scramble = 1'b0;
        instr_ready = 1'b0;
        jump_en = 1'b0;
        jump_addr = '0;
        ld_req = 1'b0;
        ld_addr = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rom_addr", rom_addr, 16'h0000);
        check("rst_instr", instr, 16'h0000);
        check("rst_valid", instr_valid, 0);
        check("rst_ld_data", ld_data, 16'h0000);
        check("rst_ld_done", ld_done, 0);
`ifdef ROM_FETCH_HALT_EN
        check("rst_halted", halted, 0);
`endif

        // Streaming fetch from reset.
        instr_q.push_back(16'h0000);
        instr_ready = 1'b1;
        rst_n = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!instr_valid && c < 20);
        check("fetch_latency", c, WAIT_CYCLES + 1);
        check("pc_after_fetch", rom_addr, 16'h0001);
        @(negedge clk);
        instr_ready = 1'b0;
        check("valid_drop", instr_valid, 0);

        // Backpressure holds the word and the PC.
        wait_valid(c);
        check("fetch_latency2", c, WAIT_CYCLES + 1);
        for (int i = 0; i < 5; i++) begin
            check("stall_instr", instr, 16'h2501);
            check("stall_valid", instr_valid, 1);
            check("stall_addr", rom_addr, 16'h0002);
            @(negedge clk);
        end
        instr_q.push_back(16'h2501);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        accept_next(16'h2500);

        // Data load at the instruction boundary.
        instr_q.push_back(16'h6D00);
        wait_valid(c);
        check("addr_before_load", rom_addr, 16'h0004);
        ld_req = 1'b1;
        ld_addr = 16'h0102;
        ld_q.push_back(16'h00BE);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("load_addr", rom_addr, 16'h0102);
            check("load_no_done", ld_done, 0);
            @(negedge clk);
        end
        check("ld_done_pulse", ld_done, 1);
        check("ld_data_direct", ld_data, 16'h00BE);
        check("addr_after_load", rom_addr, 16'h0004);
        ld_req = 1'b0;
        @(negedge clk);
        check("ld_done_single", ld_done, 0);
        accept_next(16'h6D05);

        // Jump at wcnt=1 restarts the access.
        @(negedge clk);
        jump_en = 1'b1;
        jump_addr = 16'h0006;
        @(negedge clk);
        jump_en = 1'b0;
        instr_q.push_back(16'h2430);
        wait_valid(c);
        check("jump_latency", c, WAIT_CYCLES + 1);
        check("jump_pc", rom_addr, 16'h0007);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        accept_next(16'h0F00);
`ifdef ROM_FETCH_HALT_EN
        check("halted", halted, 1);
        ld_req = 1'b1;
        ld_addr = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            check("halt_no_valid", instr_valid, 0);
            check("halt_addr", rom_addr, 16'h0008);
            @(negedge clk);
        end
        ld_req = 1'b0;
        jump_en = 1'b1;
        jump_addr = 16'h0000;
        @(negedge clk);
        jump_en = 1'b0;
        check("halt_exit", halted, 0);
        accept_next(16'h0000);
`else
        check("addr_after_0f00", rom_addr, 16'h0008);
        accept_next(16'h0000);
`endif

        // PC wrap at the top of the address space.
        jump_en = 1'b1;
        jump_addr = 16'hFFFF;
        @(negedge clk);
        jump_en = 1'b0;
        check("jump_ffff_addr", rom_addr, 16'hFFFF);
        accept_next(16'h0000);
        check("wrap_addr", rom_addr, 16'h0000);
        accept_next(16'h0000);

        // Jump while a word is held: discarded without ready, consumed with ready.
        wait_valid(c);
        jump_en = 1'b1;
        jump_addr = 16'h0005;
        @(negedge clk);
        jump_en = 1'b0;
        check("jump_discard_valid", instr_valid, 0);
        check("jump_discard_addr", rom_addr, 16'h0005);
        accept_next(16'h4600);
        instr_q.push_back(16'h2430);
        wait_valid(c);
        jump_en = 1'b1;
        jump_addr = 16'h0003;
        instr_ready = 1'b1;
        @(negedge clk);
        jump_en = 1'b0;
        instr_ready = 1'b0;
        check("jump_hs_valid", instr_valid, 0);
        accept_next(16'h6D00);

        // Reset in the middle of a load.
        instr_q.push_back(16'h6D05);
        wait_valid(c);
        ld_req = 1'b1;
        ld_addr = 16'h0100;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("load6_addr", rom_addr, 16'h0100);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        ld_req = 1'b0;
        scramble = 1'b1;
        check("mid_rst_addr", rom_addr, 16'h0000);
        check("mid_rst_valid", instr_valid, 0);
        check("mid_rst_instr", instr, 16'h0000);
        check("mid_rst_ld_data", ld_data, 16'h0000);
        check("mid_rst_ld_done", ld_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        accept_next(rom_word(16'h0000, scramble));
        accept_next(rom_word(16'h0001, scramble));

        // Randomized segments: jump to A, then expect ROM[A], ROM[A+1], ... under random
        // backpressure and interleaved loads.
        for (int s = 0; s < 30 && !abort; s++) begin
            instr_ready = 1'b0;
            repeat ($urandom_range(0, 6)) @(negedge clk);
            case ($urandom_range(0, 3))
                0, 1:    a = 16'($urandom_range(0, 15));
                2:       a = 16'h00FC + 16'($urandom_range(0, 9));
                default: a = 16'($urandom);
            endcase
            if (s == 5) a = 16'hFFFD;
            jump_en = 1'b1;
            jump_addr = a;
            @(negedge clk);
            jump_en = 1'b0;
            n = $urandom_range(3, 8);
            exp_halt = 1'b0;
            for (int k = 0; k < n; k++) begin
                w = rom_word(a + 16'(k), scramble);
                instr_q.push_back(w);
`ifdef ROM_FETCH_HALT_EN
                if (w == HALT_OPCODE) begin
                    exp_halt = 1'b1;
                    halt_pc = a + 16'(k) + 16'd1;
                    break;
                end
`endif
            end
            budget = 0;
            while ((instr_q.size() != 0 || ld_req) && budget < 300) begin
                if (ld_req && ld_done) begin
                    ld_req = 1'b0;
                end else if (!ld_req && instr_q.size() >= 2 && $urandom_range(0, 4) == 0) begin
                    ld_addr = ($urandom_range(0, 1) == 0) ? 16'h0100 + 16'($urandom_range(0, 7))
                                                          : 16'($urandom);
                    ld_q.push_back(rom_word(ld_addr, scramble));
                    ld_req = 1'b1;
                end
                instr_ready = (instr_q.size() != 0) && ($urandom_range(0, 3) != 0);
                @(negedge clk);
                budget++;
            end
            instr_ready = 1'b0;
            if (budget >= 300) begin
                fail_now("segment_timeout");
                abort = 1'b1;
                ld_req = 1'b0;
                instr_q.delete();
                ld_q.delete();
            end else if (exp_halt) begin
`ifdef ROM_FETCH_HALT_EN
                repeat (2) @(negedge clk);
                check("rand_halted", halted, 1);
                check("rand_halt_addr", rom_addr, halt_pc);
                check("rand_halt_valid", instr_valid, 0);
`endif
            end
        end

        repeat (4) @(negedge clk);
        check("instr_q_drained", instr_q.size(), 0);
        check("ld_q_drained", ld_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
